alu_share_arbiter: RTL

- Shares one combinational ALU instance between two requesters: requester 0 is the main datapath; requester 1 is an auxiliary unit such as a branch/address helper.
- Round-robin arbitration and a valid/ready request handshake with operand capture.
- Drives the ALU from registered operands, captures result/zero, and returns them through a per-requester response handshake with backpressure.
- Sits between the requesters and the ALU instance.

---
 rtl/alu_share_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two requesters,
// registering operands, capturing the result and returning it over a per-requester response handshake.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 4,
  parameter int NUM_OPS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_cnt,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_cnt,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_shamt,
  output logic [OPW-1:0]   alu_cnt,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // One extra bit so NUM_OPS == 2**OPW still compares correctly
  localparam logic [OPW:0] NUM_OPS_W = (OPW+1)'(NUM_OPS);

  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             grant_q, grant_d;
  logic [OPW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [4:0]       shamt_q, shamt_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic             gnt_sel;
  logic             rsp_hs;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    shamt_d      = shamt_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp_hs       = grant_q ? rsp1_ready : rsp0_ready;
    // Contention goes to rr_ptr; otherwise whichever requester is valid
    gnt_sel      = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;

    case (state_q)
      IDLE: begin
        req0_ready = req0_valid && !gnt_sel;
        req1_ready = req1_valid && gnt_sel;
        if (req0_ready || req1_ready) begin
          state_d = EXEC;
          grant_d = gnt_sel;
          cnt_d   = gnt_sel ? req1_cnt   : req0_cnt;
          a_d     = gnt_sel ? req1_a     : req0_a;
          b_d     = gnt_sel ? req1_b     : req0_b;
          shamt_d = gnt_sel ? req1_shamt : req0_shamt;
        end
      end
      EXEC: begin
        state_d = RESP;
        if ({1'b0, cnt_q} >= NUM_OPS_W) begin
          rsp_result_d = '0;
          rsp_zero_d   = 1'b1;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_err_d    = 1'b0;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          state_d  = IDLE;
          rr_ptr_d = ~grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      shamt_q      <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      shamt_q      <= shamt_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // The ALU always sees the operand registers, so its inputs only move on acceptance
  assign alu_cnt    = cnt_q;
  assign alu_in1    = a_q;
  assign alu_in2    = b_q;
  assign alu_shamt  = shamt_q;
  assign rsp0_valid = (state_q == RESP) && !grant_q;
  assign rsp1_valid = (state_q == RESP) && grant_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);

endmodule
